// File: rtl/rvspec_stepper.sv
// Multi-cycle RISC-V stepper around a combinational rvspec: fetches one instruction,
// performs its data accesses, commits the rvspec results and emits an RVFI retire trace.
module rvspec_stepper #(
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic         clk,
  input  logic         arst_n,

  output logic         ibus_valid,
  output logic [31:0]  ibus_addr,
  input  logic         ibus_ready,
  input  logic [31:0]  ibus_rdata,

  output logic         dbus_valid,
  output logic [31:0]  dbus_addr,
  output logic [3:0]   dbus_wen,
  output logic [31:0]  dbus_wdata,
  input  logic         dbus_ready,
  input  logic [31:0]  dbus_rdata,

  output logic [31:0]  spec_instr,
  output logic [31:0]  spec_pc,
  output logic [991:0] spec_regs,
  output logic [31:0]  spec_loadData,

  input  logic [31:0]  spec_nextPC,
  input  logic         spec_exception,
  input  logic [3:0]   spec_loadEnable,
  input  logic [31:0]  spec_loadAddress,
  input  logic [3:0]   spec_storeEnable,
  input  logic [31:0]  spec_storeAddress,
  input  logic [31:0]  spec_storeData,
  input  logic [991:0] spec_registers,

  output logic         rvfi_valid,
  output logic [63:0]  rvfi_order,
  output logic [31:0]  rvfi_insn,
  output logic [31:0]  rvfi_pc_rdata,
  output logic [31:0]  rvfi_pc_wdata,
  output logic         rvfi_trap,
  output logic [31:0]  rvfi_mem_addr,
  output logic [3:0]   rvfi_mem_rmask,
  output logic [3:0]   rvfi_mem_wmask,
  output logic [31:0]  rvfi_mem_rdata,
  output logic [31:0]  rvfi_mem_wdata,

  output logic         halted
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    EXEC   = 3'd1,
    LOAD   = 3'd2,
    STORE  = 3'd3,
    COMMIT = 3'd4,
    HALT   = 3'd5
  } state_t;

  state_t        state_q;
  logic [31:0]   pc_q;
  logic [31:0]   insn_q;
  logic [31:0]   load_q;
  logic [991:0]  regs_q;   // {x31..x1}; x0 is implicit zero
  logic          trap_q;
  logic [63:0]   order_q;
  logic          halted_q;

  // NOTE: all state uses non-blocking assignments so every register samples the
  // pre-edge values of its neighbours, regardless of statement order.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q  <= FETCH;
      pc_q     <= RESET_PC;
      insn_q   <= '0;
      load_q   <= '0;
      // NOTE: the register file is built from flops rather than a RAM because
      // x1..x31 must read as zero immediately after reset.
      regs_q   <= '0;
      trap_q   <= 1'b0;
      order_q  <= '0;
      halted_q <= 1'b0;
    end else begin
      case (state_q)
        FETCH: begin
          if (ibus_ready) begin
            insn_q  <= ibus_rdata;
            load_q  <= '0;
            trap_q  <= 1'b0;
            state_q <= EXEC;
          end
        end
        EXEC: begin
          if (spec_exception) begin
            trap_q  <= 1'b1;
            state_q <= COMMIT;
          end else if (|spec_loadEnable) begin
            state_q <= LOAD;
          end else if (|spec_storeEnable) begin
            state_q <= STORE;
          end else begin
            state_q <= COMMIT;
          end
        end
        LOAD: begin
          // The store decision uses the pre-load rvspec view; store enables never
          // depend on the loaded data.
          if (dbus_ready) begin
            load_q  <= dbus_rdata;
            state_q <= (|spec_storeEnable) ? STORE : COMMIT;
          end
        end
        STORE: begin
          if (dbus_ready) state_q <= COMMIT;
        end
        COMMIT: begin
          order_q <= order_q + 64'd1;
          if (trap_q) begin
            halted_q <= 1'b1;
            state_q  <= HALT;
          end else begin
            pc_q    <= spec_nextPC;
            regs_q  <= spec_registers;
            state_q <= FETCH;
          end
        end
        HALT: state_q <= HALT;
        default: state_q <= FETCH;
      endcase
    end
  end

  assign spec_pc       = pc_q;
  assign spec_instr    = insn_q;
  assign spec_regs     = regs_q;
  assign spec_loadData = load_q;
  assign halted        = halted_q;

  // Reset parks the FSM in FETCH, so the fetch request is also qualified by the
  // reset pin to keep the bus idle while reset is held.
  assign ibus_valid = arst_n && (state_q == FETCH);
  assign ibus_addr  = pc_q;

  // NOTE: every output of a combinational block gets a default first, so no path
  // leaves a value unassigned and no latch is inferred.
  always_comb begin
    dbus_valid = 1'b0;
    dbus_addr  = '0;
    dbus_wen   = '0;
    dbus_wdata = '0;
    case (state_q)
      LOAD: begin
        dbus_valid = 1'b1;
        dbus_addr  = spec_loadAddress;
      end
      STORE: begin
        dbus_valid = 1'b1;
        dbus_addr  = spec_storeAddress;
        dbus_wen   = spec_storeEnable;
        dbus_wdata = spec_storeData;
      end
      default: ;
    endcase
  end

  always_comb begin
    rvfi_valid     = 1'b0;
    rvfi_order     = '0;
    rvfi_insn      = '0;
    rvfi_pc_rdata  = '0;
    rvfi_pc_wdata  = '0;
    rvfi_trap      = 1'b0;
    rvfi_mem_addr  = '0;
    rvfi_mem_rmask = '0;
    rvfi_mem_wmask = '0;
    rvfi_mem_rdata = '0;
    rvfi_mem_wdata = '0;
    if (state_q == COMMIT) begin
      rvfi_valid     = 1'b1;
      rvfi_order     = order_q;
      rvfi_insn      = insn_q;
      rvfi_pc_rdata  = pc_q;
      rvfi_trap      = trap_q;
      rvfi_pc_wdata  = trap_q ? 32'h0 : spec_nextPC;
      rvfi_mem_rmask = trap_q ? 4'h0 : spec_loadEnable;
      rvfi_mem_wmask = trap_q ? 4'h0 : spec_storeEnable;
      if (|spec_loadEnable)       rvfi_mem_addr = spec_loadAddress;
      else if (|spec_storeEnable) rvfi_mem_addr = spec_storeAddress;
      rvfi_mem_rdata = load_q;
      rvfi_mem_wdata = spec_storeData;
    end
  end

  a_bus_exclusive: assert property (@(posedge clk) disable iff (!arst_n)
    !(ibus_valid && dbus_valid));

endmodule
